iob_cache_line_xfer: RTL and testbench

//  Responder end of the cache back-end buffer interface. Accepts one line-wide request, either a

---
 rtl/iob_cache_line_xfer_pkg.sv | 10 +
 rtl/iob_cache_line_xfer_if.sv | 24 ++
 rtl/iob_cache_line_xfer_asm.sv | 40 ++++
 rtl/iob_cache_line_xfer.sv | 115 +++++++++++
 tb/tb_iob_cache_line_xfer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_cache_line_xfer_pkg.sv
// Shared constants for the cache line transfer block.
// FSM encodings live here so all files agree on them.
package iob_cache_line_xfer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/iob_cache_line_xfer_if.sv
// IOb native bus bundle.
// Used for both the line-wide buffer port and the word-wide memory port.
interface iob_cache_line_xfer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  avalid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  ready;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;

   modport master (
      output avalid, addr, wdata, wstrb,
      input  ready, rdata, rvalid
   );

   modport slave (
      input  avalid, addr, wdata, wstrb,
      output ready, rdata, rvalid
   );
endinterface

// File: rtl/iob_cache_line_xfer_asm.sv
// Fill-side line assembler.
// Read words land in slot rcnt, in arrival order.
module iob_cache_line_xfer_asm #(
   parameter int DATA_W        = 32,
   parameter int WORD_OFFSET_W = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clr_i,
   input  logic                                we_i,
   input  logic [DATA_W-1:0]                   wdata_i,
   output logic [DATA_W*(1<<WORD_OFFSET_W)-1:0] line_o,
   output logic [WORD_OFFSET_W:0]              rcnt_o
);
   localparam int BLKSZ = 1 << WORD_OFFSET_W;
   localparam int CNT_W = WORD_OFFSET_W + 1;
   localparam int IDX_W = (WORD_OFFSET_W > 0) ? WORD_OFFSET_W : 1;

   logic [BLKSZ-1:0][DATA_W-1:0] words;
   logic [CNT_W-1:0]             rcnt;
   logic [IDX_W-1:0]             idx;

   assign idx = IDX_W'(rcnt);

   // store each returned word and advance the fill pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rcnt  <= '0;
         words <= '0;
      end else if (clr_i) begin
         rcnt <= '0;
      end else if (we_i) begin
         words[idx] <= wdata_i;
         rcnt       <= rcnt + CNT_W'(1);
      end
   end

   assign line_o = words;
   assign rcnt_o = rcnt;
endmodule

// File: rtl/iob_cache_line_xfer.sv
// Cache back-end line transfer: one line request in,
// BLKSZ word transactions out on the memory port.
module iob_cache_line_xfer
   import iob_cache_line_xfer_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int WORD_OFFSET_W = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   iob_cache_line_xfer_if.slave   buf_iob,
   iob_cache_line_xfer_if.master  mem_iob,
   output logic                   busy_o
);
   localparam int NBYTES     = DATA_W / 8;
   localparam int NBYTES_W   = $clog2(NBYTES);
   localparam int BLKSZ      = 1 << WORD_OFFSET_W;
   localparam int LINE_W     = DATA_W * BLKSZ;
   localparam int BUF_ADDR_W = ADDR_W - WORD_OFFSET_W;
   localparam int MEM_ADDR_W = ADDR_W + NBYTES_W;
   localparam int CNT_W      = WORD_OFFSET_W + 1;
   localparam int IDX_W      = (WORD_OFFSET_W > 0) ? WORD_OFFSET_W : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLKSZ - 1);
   localparam logic [CNT_W-1:0] ENDC = CNT_W'(BLKSZ);

   logic [1:0]                   state;
   logic [CNT_W-1:0]             wcnt;
   logic [CNT_W-1:0]             rcnt;
   logic [IDX_W-1:0]             widx;
   logic [BUF_ADDR_W-1:0]        line_addr;
   logic [BLKSZ-1:0][DATA_W-1:0] wd_r;
   logic [BLKSZ-1:0][NBYTES-1:0] ws_r;
   logic [LINE_W-1:0]            line;
   logic [LINE_W-1:0]            rdata_r;
   logic is_idle, is_wr, is_rd, is_resp;
   logic accept, skip, issue, adv, rd_we, rd_last;

   assign is_idle = (state == ST_IDLE);
   assign is_wr   = (state == ST_WR);
   assign is_rd   = (state == ST_RD);
   assign is_resp = (state == ST_RESP);

   assign widx    = IDX_W'(wcnt);
   assign accept  = is_idle & buf_iob.avalid;
   assign skip    = is_wr & ~|ws_r[widx];
   assign issue   = ~rst_i & ((is_wr & ~skip) | (is_rd & (wcnt != ENDC)));
   assign adv     = skip | (issue & mem_iob.ready);
   assign rd_we   = is_rd & mem_iob.rvalid;
   assign rd_last = rd_we & (rcnt == LAST);

   // request capture, word issue counter and FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         wcnt      <= '0;
         line_addr <= '0;
         wd_r      <= '0;
         ws_r      <= '0;
      end else begin
         unique case (1'b1)
            is_idle: if (accept) begin
               line_addr <= buf_iob.addr;
               wd_r      <= buf_iob.wdata;
               ws_r      <= buf_iob.wstrb;
               wcnt      <= '0;
               state     <= (|buf_iob.wstrb) ? ST_WR : ST_RD;
            end
            is_wr: if (adv) begin
               wcnt <= wcnt + CNT_W'(1);
               if (wcnt == LAST) state <= ST_IDLE;
            end
            is_rd: begin
               if (issue & mem_iob.ready) wcnt <= wcnt + CNT_W'(1);
               if (rd_last) state <= ST_RESP;
            end
            is_resp: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // keep the last delivered line visible until the next fill completes
   always_ff @(posedge clk_i) begin
      if (rst_i) rdata_r <= '0;
      else if (is_resp) rdata_r <= line;
   end

   iob_cache_line_xfer_asm #(
      .DATA_W       (DATA_W),
      .WORD_OFFSET_W(WORD_OFFSET_W)
   ) u_asm (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (accept),
      .we_i   (rd_we),
      .wdata_i(mem_iob.rdata),
      .line_o (line),
      .rcnt_o (rcnt)
   );

   assign buf_iob.ready  = ~rst_i & is_idle;
   assign buf_iob.rvalid = ~rst_i & is_resp;
   assign buf_iob.rdata  = rst_i ? '0 : (is_resp ? line : rdata_r);

   assign mem_iob.avalid = issue;
   assign mem_iob.addr   = issue
      ? ((MEM_ADDR_W'(line_addr) << (WORD_OFFSET_W + NBYTES_W))
        | (MEM_ADDR_W'(widx) << NBYTES_W))
      : '0;
   assign mem_iob.wdata  = (issue & is_wr) ? wd_r[widx] : '0;
   assign mem_iob.wstrb  = (issue & is_wr) ? ws_r[widx] : '0;

   assign busy_o = ~rst_i & ~is_idle;
endmodule

// File: tb/tb_iob_cache_line_xfer.sv
// Bench for iob_cache_line_xfer: BLKSZ=4 and BLKSZ=1 instances
// sharing one memory model selected by sel.
module tb_iob_cache_line_xfer;
   localparam int P = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #(P/2) clk = ~clk;

   iob_cache_line_xfer_if #(.ADDR_W(30), .DATA_W(128)) b4 ();
   iob_cache_line_xfer_if #(.ADDR_W(34), .DATA_W(32))  m4 ();
   iob_cache_line_xfer_if #(.ADDR_W(32), .DATA_W(32))  b1 ();
   iob_cache_line_xfer_if #(.ADDR_W(34), .DATA_W(32))  m1 ();
   logic busy4, busy1;

   iob_cache_line_xfer #(
      .ADDR_W(32), .DATA_W(32), .WORD_OFFSET_W(2)
   ) dut4 (
      .clk_i(clk), .rst_i(rst), .buf_iob(b4), .mem_iob(m4), .busy_o(busy4)
   );

   iob_cache_line_xfer #(
      .ADDR_W(32), .DATA_W(32), .WORD_OFFSET_W(0)
   ) dut1 (
      .clk_i(clk), .rst_i(rst), .buf_iob(b1), .mem_iob(m1), .busy_o(busy1)
   );

   typedef struct packed {
      logic        rd;
      logic [33:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   txn_t         mq[$];
   logic [127:0] lq[$];
   logic [31:0]  rq_d[$];
   int           rq_c[$];

   int   checks = 0;
   int   failures = 0;
   int   ncyc = 0;
   int   rv_cnt = 0;
   bit   sel = 1'b0;
   int   rdy_mode = 0;
   int   rv_min = 0;
   int   rv_max = 0;
   int   exp_lat = -1;
   logic [7:0] rd_base = 8'hA0;
   time  t_acc = 0;
   bit   stall_prev = 1'b0;
   logic [69:0] held = '0;

   logic         m_av, b_ready, b_rv;
   logic [33:0]  m_addr;
   logic [31:0]  m_wd;
   logic [3:0]   m_ws;
   logic [127:0] b_rd;

   assign m_av    = sel ? m1.avalid : m4.avalid;
   assign m_addr  = sel ? m1.addr   : m4.addr;
   assign m_wd    = sel ? m1.wdata  : m4.wdata;
   assign m_ws    = sel ? m1.wstrb  : m4.wstrb;
   assign b_ready = sel ? b1.ready  : b4.ready;
   assign b_rv    = sel ? b1.rvalid : b4.rvalid;
   assign b_rd    = sel ? {96'h0, b1.rdata} : b4.rdata;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory model: ready pattern, in-order read returns
   always @(negedge clk) begin
      logic rdy, rv;
      logic [31:0] rd;
      txn_t e;
      ncyc++;
      if (stall_prev && !rst)
         chk("mem_hold", {m_av, m_addr, m_wd, m_ws}, {1'b1, held});
      rv = 1'b0;
      rd = '0;
      if (rq_c.size() > 0 && rq_c[0] <= ncyc) begin
         rv = 1'b1;
         rd = rq_d.pop_front();
         void'(rq_c.pop_front());
         rv_cnt++;
      end
      case (rdy_mode)
         0: rdy = 1'b1;
         1: rdy = (ncyc % 2) == 1;
         default: rdy = 1'($urandom_range(0, 1));
      endcase
      m4.ready  = !sel & rdy;
      m1.ready  = sel & rdy;
      m4.rvalid = !sel & rv;
      m1.rvalid = sel & rv;
      m4.rdata  = rd;
      m1.rdata  = rd;
      stall_prev = m_av & !rdy & !rst;
      held = {m_addr, m_wd, m_ws};
      if (m_av && rdy && !rst) begin
         if (mq.size() == 0) begin
            chk("mem_spurious", 1, 0);
         end else begin
            e = mq.pop_front();
            chk("mem_addr", m_addr, e.addr);
            chk("mem_wstrb", m_ws, e.wstrb);
            if (!e.rd) chk("mem_wdata", m_wd, e.wdata);
            if (e.rd) begin
               rq_d.push_back({24'h0, rd_base + 8'(m_addr[3:2])});
               rq_c.push_back(ncyc + 1 + $urandom_range(rv_min, rv_max));
            end
         end
      end
   end

   // buffer-side monitor: every fill pulse must match a queued line
   always @(negedge clk) begin
      if (!rst && b_rv) begin
         if (lq.size() == 0) chk("buf_rv_spurious", 1, 0);
         else chk("buf_line", b_rd, lq.pop_front());
         if (exp_lat > 0) begin
            chk("fill_latency", 128'(($time - t_acc + P/2) / P), 128'(exp_lat));
            exp_lat = -1;
         end
      end
   end

   task automatic req(logic [31:0] la, logic [127:0] wd, logic [15:0] ws);
      @(posedge clk); #1;
      if (sel) begin
         b1.avalid = 1'b1; b1.addr = la; b1.wdata = wd[31:0]; b1.wstrb = ws[3:0];
      end else begin
         b4.avalid = 1'b1; b4.addr = la[29:0]; b4.wdata = wd; b4.wstrb = ws;
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (b_ready) begin
            @(posedge clk);
            t_acc = $time;
            #1;
            b4.avalid = 1'b0;
            b1.avalid = 1'b0;
            return;
         end
      end
      chk("req_timeout", 0, 1);
      b4.avalid = 1'b0;
      b1.avalid = 1'b0;
   endtask

   task automatic wait_ready(output int lat);
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (b_ready) begin
            lat = int'(($time - t_acc + P/2) / P);
            return;
         end
      end
      chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rq_d.size() == 0 && mq.size() == 0) return;
      end
      chk("drain_timeout", 0, 1);
   endtask

   task automatic push_rd(logic [33:0] a);
      mq.push_back('{rd: 1'b1, addr: a, wdata: 32'h0, wstrb: 4'h0});
   endtask

   task automatic push_wr(logic [33:0] a, logic [31:0] d, logic [3:0] s);
      mq.push_back('{rd: 1'b0, addr: a, wdata: d, wstrb: s});
   endtask

   initial begin
      int lat;
      logic [127:0] ln;
      logic [127:0] wl;
      logic [15:0]  ws;
      b4.avalid = 0; b4.addr = '0; b4.wdata = '0; b4.wstrb = '0;
      b1.avalid = 0; b1.addr = '0; b1.wdata = '0; b1.wstrb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {b4.ready, b4.rvalid, m4.avalid, busy4, b1.ready}, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {b4.ready, b1.ready}, 2'b11);
      chk("post_rst_ctl", {m4.avalid, b4.rvalid, busy4, m4.addr}, 0);
      chk("post_rst_rdata", b4.rdata, 0);

      // fill, zero-wait memory
      for (int k = 0; k < 4; k++) push_rd(34'h1000 + 34'(4*k));
      lq.push_back(128'h000000A3_000000A2_000000A1_000000A0);
      exp_lat = 6;
      req(32'h100, '0, '0);
      wait_ready(lat);
      repeat (3) @(posedge clk);
      #1;
      chk("rdata_hold", b4.rdata, 128'h000000A3_000000A2_000000A1_000000A0);

      // write-back with ready toggling
      rdy_mode = 1;
      wl = 128'h44444444_33333333_22222222_11111111;
      for (int k = 0; k < 4; k++)
         push_wr(34'h400 + 34'(4*k), wl[32*k +: 32], 4'hF);
      req(32'h40, wl, 16'hFFFF);
      wait_ready(lat);
      chk("wb_ready_after_last", mq.size(), 0);

      // write with two empty word strobes
      rdy_mode = 0;
      wl = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
      push_wr(34'h800, wl[31:0], 4'hF);
      push_wr(34'h808, wl[95:64], 4'hF);
      req(32'h80, wl, 16'h0F0F);
      wait_ready(lat);
      chk("wr_ready_latency", lat, 5);
      chk("wr_skip_drained", mq.size(), 0);

      // fill with delayed, gapped returns and random ready
      rdy_mode = 2; rv_min = 2; rv_max = 5; rd_base = 8'h50;
      ln = '0;
      for (int k = 0; k < 4; k++) begin
         push_rd(34'h3F00 + 34'(4*k));
         ln[32*k +: 32] = {24'h0, 8'h50 + 8'(k)};
      end
      lq.push_back(ln);
      req(32'h3F0, '0, '0);
      wait_ready(lat);

      // reset mid-fill, stale returns afterwards
      rdy_mode = 0; rv_min = 2; rv_max = 2; rd_base = 8'h70;
      for (int k = 0; k < 4; k++) push_rd(34'h2000 + 34'(4*k));
      rv_cnt = 0;
      req(32'h200, '0, '0);
      for (int i = 0; i < 50 && rv_cnt < 2; i++) begin
         @(posedge clk); #1;
      end
      chk("two_words_back", rv_cnt, 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {b4.ready, b4.rvalid, m4.avalid, busy4}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_idle", {b4.ready, busy4}, 2'b10);
      chk("abort_rdata", b4.rdata, 0);
      wait_drain();
      repeat (2) @(posedge clk);
      rv_min = 0; rv_max = 0; rd_base = 8'hC0;
      for (int k = 0; k < 4; k++) push_rd(34'h1000 + 34'(4*k));
      lq.push_back(128'h000000C3_000000C2_000000C1_000000C0);
      exp_lat = 6;
      req(32'h100, '0, '0);
      wait_ready(lat);

      // single-word line instance
      sel = 1'b1;
      rd_base = 8'h30;
      push_rd(34'h48C);
      lq.push_back({96'h0, 24'h0, 8'h33});
      exp_lat = 3;
      req(32'h123, '0, '0);
      wait_ready(lat);
      ws = 16'h6;
      push_wr(34'h154, 32'hDEADBEEF, 4'h6);
      req(32'h55, 128'hDEADBEEF, ws);
      wait_ready(lat);
      chk("w1_ready_latency", lat, 2);
      repeat (3) @(posedge clk);
      #1;
      chk("w1_rdata_hold", b1.rdata, 32'h00000033);

      chk("mq_drained", mq.size(), 0);
      chk("lq_drained", lq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
